// File: rtl/psram_arbiter_if.sv
// Bundle between the PSRAM arbiter, the quad-SPI PSRAM controller and the two requesters.
// The slave modport is the arbiter's view; master is the environment driving it.
interface psram_arbiter_if;
    localparam int unsigned ADDR_W = 23;
    localparam int unsigned DATA_W = 16;

    logic              qpi_on;
    logic              endcommand;
    logic [DATA_W-1:0] psram_data_out;
    logic [ADDR_W-1:0] psram_address;
    logic [1:0]        psram_read_write;
    logic              psram_quad_start;
    logic [DATA_W-1:0] psram_data_in;

    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              timeout_err;

    modport slave (
        input  qpi_on, endcommand, psram_data_out,
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr,
        output psram_address, psram_read_write, psram_quad_start, psram_data_in,
        output wr_ack, rd_valid, rd_data, busy, timeout_err
    );

    modport master (
        output qpi_on, endcommand, psram_data_out,
        output wr_req, wr_addr, wr_data, rd_req, rd_addr,
        input  psram_address, psram_read_write, psram_quad_start, psram_data_in,
        input  wr_ack, rd_valid, rd_data, busy, timeout_err
    );
endinterface

// File: rtl/psram_arbiter.sv
// Sequencer and write/read arbiter sharing one quad-SPI PSRAM channel, with
// endcommand blanking, inter-op gap and a completion watchdog.
module psram_arbiter #(
    parameter int unsigned BLANK        = 2,
    parameter int unsigned GAP          = 2,
    parameter int unsigned TIMEOUT      = 64,
    parameter int unsigned MAX_WR_BURST = 8
) (
    input  logic           mem_clk,
    input  logic           rst,
    psram_arbiter_if.slave bus
);
    localparam int unsigned ADDR_W  = 23;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned WD_W    = 8;
    localparam int unsigned BURST_W = 4;

    localparam logic [1:0] RW_NONE  = 2'd0;
    localparam logic [1:0] RW_WRITE = 2'd1;
    localparam logic [1:0] RW_READ  = 2'd2;

    localparam logic [CNT_W-1:0]   BLANK_LAST = CNT_W'(BLANK - 1);
    localparam logic [CNT_W-1:0]   GAP_LAST   = CNT_W'(GAP - 1);
    localparam logic [WD_W-1:0]    WD_LAST    = WD_W'(TIMEOUT - 1);
    localparam logic [BURST_W-1:0] BURST_MAX  = BURST_W'(MAX_WR_BURST);

    typedef enum logic [2:0] {INIT, IDLE, ISSUE, BLANK_W, WAIT_END, GAP_W} state_t;

    state_t              state_q, state_d;
    state_t              end_state_c;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WD_W-1:0]     wdog_q, wdog_d;
    logic [BURST_W-1:0]  burst_q, burst_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic [1:0]          rw_q, rw_d;
    logic                qs_q, qs_d;
    logic                wr_ack_q, wr_ack_d;
    logic                rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                busy_q, busy_d;
    logic                terr_q, terr_d;
    logic                grant_rd_c;
    logic                finish_c;
    logic                abort_c;

    // State register
    always_ff @(posedge mem_clk) begin
        if (rst) state_q <= INIT;
        else     state_q <= state_d;
    end

    // Next state and next values of every registered output
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wdog_d      = wdog_q;
        burst_d     = burst_q;
        addr_d      = addr_q;
        din_d       = din_q;
        rw_d        = rw_q;
        qs_d        = 1'b0;
        wr_ack_d    = 1'b0;
        rd_valid_d  = 1'b0;
        rd_data_d   = rd_data_q;
        terr_d      = terr_q;
        grant_rd_c  = 1'b0;
        finish_c    = 1'b0;
        abort_c     = 1'b0;
        end_state_c = bus.qpi_on ? IDLE : INIT;

        unique case (state_q)
            INIT: begin
                if (bus.qpi_on) state_d = IDLE;
            end
            IDLE: begin
                if (!bus.qpi_on) begin
                    state_d = INIT;
                end else if (bus.wr_req || bus.rd_req) begin
                    // Writes win unless they have already starved a pending read for a full burst
                    grant_rd_c = bus.rd_req && (!bus.wr_req || burst_q == BURST_MAX);
                    if (grant_rd_c) begin
                        addr_d  = bus.rd_addr;
                        rw_d    = RW_READ;
                        burst_d = '0;
                    end else begin
                        addr_d = bus.wr_addr;
                        din_d  = bus.wr_data;
                        rw_d   = RW_WRITE;
                        if (!bus.rd_req)            burst_d = '0;
                        else if (burst_q != BURST_MAX) burst_d = burst_q + BURST_W'(1);
                    end
                    qs_d    = 1'b1;
                    wdog_d  = '0;
                    cnt_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                wdog_d  = wdog_q + WD_W'(1);
                state_d = (BLANK == 0) ? WAIT_END : BLANK_W;
            end
            BLANK_W: begin
                wdog_d = wdog_q + WD_W'(1);
                if (wdog_q == WD_LAST) begin
                    abort_c = 1'b1;
                end else if (cnt_q == BLANK_LAST) begin
                    cnt_d   = '0;
                    state_d = WAIT_END;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_END: begin
                wdog_d = wdog_q + WD_W'(1);
                if (bus.endcommand)        finish_c = 1'b1;
                else if (wdog_q == WD_LAST) abort_c = 1'b1;
            end
            GAP_W: begin
                if (cnt_q == GAP_LAST) state_d = end_state_c;
                else                   cnt_d   = cnt_q + CNT_W'(1);
            end
            default: state_d = INIT;
        endcase

        // A watchdog abort still acknowledges the requester so nobody deadlocks
        if (finish_c || abort_c) begin
            if (rw_q == RW_WRITE) begin
                wr_ack_d = 1'b1;
            end else begin
                rd_valid_d = 1'b1;
                if (finish_c) rd_data_d = bus.psram_data_out;
            end
            if (abort_c) terr_d = 1'b1;
            rw_d    = RW_NONE;
            cnt_d   = '0;
            state_d = (GAP == 0) ? end_state_c : GAP_W;
        end

        busy_d = (state_d != INIT) && (state_d != IDLE);
    end

    // Datapath and output registers
    always_ff @(posedge mem_clk) begin
        if (rst) begin
            cnt_q      <= '0;
            wdog_q     <= '0;
            burst_q    <= '0;
            addr_q     <= '0;
            din_q      <= '0;
            rw_q       <= RW_NONE;
            qs_q       <= 1'b0;
            wr_ack_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            busy_q     <= 1'b0;
            terr_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            wdog_q     <= wdog_d;
            burst_q    <= burst_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            rw_q       <= rw_d;
            qs_q       <= qs_d;
            wr_ack_q   <= wr_ack_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            busy_q     <= busy_d;
            terr_q     <= terr_d;
        end
    end

    assign bus.psram_address    = addr_q;
    assign bus.psram_data_in    = din_q;
    assign bus.psram_read_write = rw_q;
    assign bus.psram_quad_start = qs_q;
    assign bus.wr_ack           = wr_ack_q;
    assign bus.rd_valid         = rd_valid_q;
    assign bus.rd_data          = rd_data_q;
    assign bus.busy             = busy_q;
    assign bus.timeout_err      = terr_q;
endmodule
